// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants shared by the sync generator and overlay blocks.
package vga_timing_pkg;
   localparam int COORD_W       = 10;

   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel enable: toggle divider when VGA_SYNC_PIXEL_DIV_EN is defined, else constant 1.
// Latency: first high one clk after reset release; no backpressure (free-running).
module vga_pixel_tick (
`ifdef VGA_SYNC_PIXEL_DIV_EN
   input  logic clk,
   input  logic reset,
`endif
   output logic pixel_tick
);

`ifdef VGA_SYNC_PIXEL_DIV_EN
   logic tick_q;

   always_ff @(posedge clk) begin
      if (reset) tick_q <= 1'b0;
      else       tick_q <= ~tick_q;
   end

   assign pixel_tick = tick_q;
`else
   assign pixel_tick = 1'b1;
`endif

endmodule

// File: rtl/vga_sync_gen.sv
// Raster counters with registered sync/blank/tick decodes; VGA_SYNC_PIXEL_DIV_EN halves the pixel rate.
// Latency: decodes are registered from next-state counters, so they change on the counter edge.
// Backpressure: none; the raster free-runs whenever pixel_tick is high.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_DISPLAY   = vga_timing_pkg::DEF_H_DISPLAY,
   parameter int   H_FRONT     = vga_timing_pkg::DEF_H_FRONT,
   parameter int   H_SYNC      = vga_timing_pkg::DEF_H_SYNC,
   parameter int   H_BACK      = vga_timing_pkg::DEF_H_BACK,
   parameter int   V_DISPLAY   = vga_timing_pkg::DEF_V_DISPLAY,
   parameter int   V_FRONT     = vga_timing_pkg::DEF_V_FRONT,
   parameter int   V_SYNC      = vga_timing_pkg::DEF_V_SYNC,
   parameter int   V_BACK      = vga_timing_pkg::DEF_V_BACK,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   output logic [COORD_W-1:0] HCount,
   output logic [COORD_W-1:0] VCount,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               pixel_tick,
   output logic               line_tick,
   output logic               frame_tick
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   localparam logic [COORD_W-1:0] C_ONE    = COORD_W'(1);
   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [COORD_W-1:0] h_nxt;
   logic [COORD_W-1:0] v_nxt;
   logic               end_of_line;
   logic               end_of_frame;

   vga_pixel_tick u_pixel_tick (
`ifdef VGA_SYNC_PIXEL_DIV_EN
      .clk        (clk),
      .reset      (reset),
`endif
      .pixel_tick (pixel_tick)
   );

   always_comb begin
      h_nxt        = HCount;
      v_nxt        = VCount;
      end_of_line  = pixel_tick && (HCount == H_LAST);
      end_of_frame = end_of_line && (VCount == V_LAST);
      if (end_of_line) begin
         h_nxt = '0;
         v_nxt = (VCount == V_LAST) ? '0 : VCount + C_ONE;
      end else if (pixel_tick) begin
         h_nxt = HCount + C_ONE;
      end
   end

   // Decoding h_nxt/v_nxt keeps every output aligned with the counters it describes.
   always_ff @(posedge clk) begin
      if (reset) begin
         HCount     <= '0;
         VCount     <= '0;
         hsync      <= ~SYNC_ACTIVE;
         vsync      <= ~SYNC_ACTIVE;
         video_on   <= 1'b0;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         HCount     <= h_nxt;
         VCount     <= v_nxt;
         hsync      <= (h_nxt >= HS_START && h_nxt <= HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync      <= (v_nxt >= VS_START && v_nxt <= VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         video_on   <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
         line_tick  <= end_of_line;
         frame_tick <= end_of_frame;
      end
   end

endmodule
